// File: rtl/imem_responder.sv
// Instruction-memory responder: word-addressed 32-bit read port for fetch, plus a back-door write port.
// Latency: read data is registered 1 cycle after the request, or WAIT_STATES+1 cycles when wait states are configured.
// Backpressure: stall_o is high for WAIT_STATES cycles while a read is pending; writes are never stalled.
module imem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        re_i,
  input  logic [29:0] rmemaddr_i,
  output logic [31:0] rmemdata_o,
  output logic        stall_o,
  input  logic        we_i,
  input  logic [29:0] wmemaddr_i,
  input  logic [31:0] wmemdata_i,
  output logic        oor_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  // Counter load value; only meaningful when wait states are configured.
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [31:0] mem [DEPTH];

  logic [0:0]  state;
  logic [3:0]  cnt;
  logic [29:0] addr_q;

  logic [29:0] rd_addr;
  logic        rd_fire;
  logic        rd_ok;
  logic        wr_ok;
  logic [31:0] rd_word;

  // An address is valid only when every bit above the implemented range is zero.
  function automatic logic in_range(input logic [29:0] a);
    return (a >> ADDR_WIDTH) == 30'd0;
  endfunction

  // Pick the read address and the edge at which the array is sampled.
  always_comb begin
    rd_addr = rmemaddr_i;
    rd_fire = re_i;
    if (WAIT_STATES != 0) begin
      rd_addr = addr_q;
      rd_fire = (state == S_WAIT) && (cnt == 4'd0);
    end
    rd_ok   = in_range(rd_addr);
    wr_ok   = in_range(wmemaddr_i);
    rd_word = rd_ok ? mem[rd_addr[ADDR_WIDTH-1:0]] : 32'h0;
  end

  // Stall is simply "a read is pending"; the state register makes it registered.
  assign stall_o = (WAIT_STATES != 0) && (state == S_WAIT);

  // Back-door write; reset suppresses it, contents themselves are never cleared.
  always_ff @(posedge clk_i) begin
    if (!rst_i && we_i && wr_ok) begin
      mem[wmemaddr_i[ADDR_WIDTH-1:0]] <= wmemdata_i;
    end
  end

  // Read data, sticky out-of-range flag and the wait-state sequencer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rmemdata_o <= 32'h0;
      oor_o      <= 1'b0;
      state      <= S_IDLE;
      cnt        <= 4'd0;
      addr_q     <= 30'd0;
    end else begin
      if (rd_fire) begin
        rmemdata_o <= rd_word;
      end
      if ((rd_fire && !rd_ok) || (we_i && !wr_ok)) begin
        oor_o <= 1'b1;
      end
      if (WAIT_STATES != 0) begin
        case (state)
          S_IDLE: begin
            if (re_i) begin
              addr_q <= rmemaddr_i;
              cnt    <= CNT_INIT;
              state  <= S_WAIT;
            end
          end
          S_WAIT: begin
            // Request inputs are ignored here; fetch is frozen by stall_o.
            if (cnt == 4'd0) begin
              state <= S_IDLE;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

  typedef struct {
    logic        rst;
    logic        re;
    logic [29:0] ra;
    logic        we;
    logic [29:0] wa;
    logic [31:0] wd;
    logic [31:0] e_rd;
    logic        e_stall;
    logic        e_oor;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        st;
    logic        oor;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: no wait states
  logic        a_rst = 1'b1, a_re = 1'b0, a_we = 1'b0;
  logic [29:0] a_ra = '0, a_wa = '0;
  logic [31:0] a_wd = '0, a_rd;
  logic        a_stall, a_oor;

  // Instance B: three wait states
  logic        b_rst = 1'b1, b_re = 1'b0, b_we = 1'b0;
  logic [29:0] b_ra = '0, b_wa = '0;
  logic [31:0] b_wd = '0, b_rd;
  logic        b_stall, b_oor;

  imem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_ws0 (
    .clk_i(clk), .rst_i(a_rst), .re_i(a_re), .rmemaddr_i(a_ra), .rmemdata_o(a_rd),
    .stall_o(a_stall), .we_i(a_we), .wmemaddr_i(a_wa), .wmemdata_i(a_wd), .oor_o(a_oor)
  );

  imem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u_ws3 (
    .clk_i(clk), .rst_i(b_rst), .re_i(b_re), .rmemaddr_i(b_ra), .rmemdata_o(b_rd),
    .stall_o(b_stall), .we_i(b_we), .wmemaddr_i(b_wa), .wmemdata_i(b_wd), .oor_o(b_oor)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic re, input logic [29:0] ra,
                              input logic we, input logic [29:0] wa, input logic [31:0] wd,
                              input logic [31:0] erd, input logic est, input logic eoor);
    vec_t v;
    v.rst = rst; v.re = re; v.ra = ra; v.we = we; v.wa = wa; v.wd = wd;
    v.e_rd = erd; v.e_stall = est; v.e_oor = eoor;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Drive one cycle of stimulus on the chosen instance, then compare after the edge.
  task automatic apply(input bit which, input vec_t v, input string tag);
    exp_t e;
    exp_t got;
    if (!which) begin
      a_rst = v.rst; a_re = v.re; a_ra = v.ra; a_we = v.we; a_wa = v.wa; a_wd = v.wd;
    end else begin
      b_rst = v.rst; b_re = v.re; b_ra = v.ra; b_we = v.we; b_wa = v.wa; b_wd = v.wd;
    end
    sb.push_back('{v.e_rd, v.e_stall, v.e_oor});
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      if (!which) got = '{a_rd, a_stall, a_oor};
      else        got = '{b_rd, b_stall, b_oor};
      check({tag, ".rdata"}, got.rd, e.rd);
      check({tag, ".stall"}, {31'd0, got.st}, {31'd0, e.st});
      check({tag, ".oor"},   {31'd0, got.oor}, {31'd0, e.oor});
    end
  endtask

  // Short-hand for the wait-state instance sequences.
  task automatic b_cyc(input logic rst, input logic re, input logic [29:0] ra,
                       input logic we, input logic [29:0] wa, input logic [31:0] wd,
                       input logic [31:0] erd, input logic est, input logic eoor,
                       input string tag);
    apply(1'b1, mk(rst, re, ra, we, wa, wd, erd, est, eoor), tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // ---------- WAIT_STATES=0 vector table ----------
    tbl.push_back(mk(1, 0, 0,      0, 0, 0,             32'h0,        0, 0));  // reset
    tbl.push_back(mk(0, 0, 0,      1, 5, 32'hDEADBEEF,  32'h0,        0, 0));
    tbl.push_back(mk(0, 0, 0,      1, 6, 32'h12345678,  32'h0,        0, 0));
    tbl.push_back(mk(0, 0, 0,      1, 7, 32'h0,         32'h0,        0, 0));
    tbl.push_back(mk(0, 0, 0,      1, 0, 32'h11111111,  32'h0,        0, 0));
    tbl.push_back(mk(0, 1, 5,      0, 0, 0,             32'hDEADBEEF, 0, 0));
    tbl.push_back(mk(0, 1, 6,      0, 0, 0,             32'h12345678, 0, 0));
    tbl.push_back(mk(0, 1, 7,      1, 7, 32'hAAAA5555,  32'h0,        0, 0));  // read-first
    tbl.push_back(mk(0, 1, 7,      0, 0, 0,             32'hAAAA5555, 0, 0));
    tbl.push_back(mk(0, 1, 30'h400, 0, 0, 0,            32'h0,        0, 1));  // oor read
    tbl.push_back(mk(0, 0, 0,      1, 30'h400, 32'hCAFEF00D, 32'h0,   0, 1));  // oor write
    tbl.push_back(mk(0, 1, 0,      0, 0, 0,             32'h11111111, 0, 1));  // no alias
    tbl.push_back(mk(0, 1, 5,      0, 0, 0,             32'hDEADBEEF, 0, 1));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(0, 0, 30'h3, 0, 0, 0,            32'hDEADBEEF, 0, 1));  // hold
    tbl.push_back(mk(1, 0, 0,      1, 0, 32'hBAD0BAD0,  32'h0,        0, 0));  // reset beats we
    tbl.push_back(mk(0, 1, 0,      0, 0, 0,             32'h11111111, 0, 0));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++)
      apply(1'b0, tbl[i], $sformatf("ws0[%0d]", i));
    a_re = 1'b0; a_we = 1'b0;

    // ---------- WAIT_STATES=3 hand-written sequences ----------
    b_cyc(1, 0, 0,  0, 0,  0,            32'h0,        0, 0, "ws3.reset");
    b_cyc(0, 0, 0,  1, 5,  32'hDEADBEEF, 32'h0,        0, 0, "ws3.w5");
    b_cyc(0, 0, 0,  1, 12, 32'h01010101, 32'h0,        0, 0, "ws3.w12");
    // basic read with address wiggle during WAIT
    b_cyc(0, 1, 5,  0, 0,  0,            32'h0,        1, 0, "ws3.rd5.k");
    b_cyc(0, 1, 9,  0, 0,  0,            32'h0,        1, 0, "ws3.rd5.k1");
    b_cyc(0, 1, 9,  0, 0,  0,            32'h0,        1, 0, "ws3.rd5.k2");
    b_cyc(0, 0, 0,  0, 0,  0,            32'hDEADBEEF, 0, 0, "ws3.rd5.k3");
    // write to pending address during WAIT is visible
    b_cyc(0, 1, 12, 0, 0,  0,            32'hDEADBEEF, 1, 0, "ws3.rd12.k");
    b_cyc(0, 0, 0,  1, 12, 32'h77778888, 32'hDEADBEEF, 1, 0, "ws3.rd12.k1");
    b_cyc(0, 0, 0,  0, 0,  0,            32'hDEADBEEF, 1, 0, "ws3.rd12.k2");
    b_cyc(0, 1, 5,  0, 0,  0,            32'h77778888, 0, 0, "ws3.rd12.k3");  // re here is ignored
    // next request accepted in the following IDLE cycle
    b_cyc(0, 1, 5,  0, 0,  0,            32'h77778888, 1, 0, "ws3.rd5b.k");
    b_cyc(0, 0, 0,  0, 0,  0,            32'h77778888, 1, 0, "ws3.rd5b.k1");
    b_cyc(0, 0, 0,  0, 0,  0,            32'h77778888, 1, 0, "ws3.rd5b.k2");
    b_cyc(0, 0, 0,  0, 0,  0,            32'hDEADBEEF, 0, 0, "ws3.rd5b.k3");
    // out-of-range read through the wait path
    b_cyc(0, 1, 30'h400, 0, 0, 0,        32'hDEADBEEF, 1, 0, "ws3.oor.k");
    b_cyc(0, 0, 0,  0, 0,  0,            32'hDEADBEEF, 1, 0, "ws3.oor.k1");
    b_cyc(0, 0, 0,  0, 0,  0,            32'hDEADBEEF, 1, 0, "ws3.oor.k2");
    b_cyc(0, 0, 0,  0, 0,  0,            32'h0,        0, 1, "ws3.oor.k3");
    // reset during the second WAIT cycle aborts the read
    b_cyc(0, 1, 5,  0, 0,  0,            32'h0,        1, 1, "ws3.abort.k");
    b_cyc(0, 0, 0,  0, 0,  0,            32'h0,        1, 1, "ws3.abort.k1");
    b_cyc(1, 0, 0,  0, 0,  0,            32'h0,        0, 0, "ws3.abort.rst");
    b_cyc(0, 0, 0,  0, 0,  0,            32'h0,        0, 0, "ws3.abort.p1");
    b_cyc(0, 0, 0,  0, 0,  0,            32'h0,        0, 0, "ws3.abort.p2");
    // fresh read after reset
    b_cyc(0, 1, 5,  0, 0,  0,            32'h0,        1, 0, "ws3.fresh.k");
    b_cyc(0, 0, 0,  0, 0,  0,            32'h0,        1, 0, "ws3.fresh.k1");
    b_cyc(0, 0, 0,  0, 0,  0,            32'h0,        1, 0, "ws3.fresh.k2");
    b_cyc(0, 0, 0,  0, 0,  0,            32'hDEADBEEF, 0, 0, "ws3.fresh.k3");
    for (int i = 0; i < 10; i++)
      b_cyc(0, 0, 30'h7, 0, 0, 0,        32'hDEADBEEF, 0, 0, $sformatf("ws3.hold[%0d]", i));

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
